bin_vec_packer: RTL
===================

// Module: bin_vec_packer
// PURPOSE
//   Input stage for the bneuron array. Takes a stream of signed DWIDTH-bit samples, binarizes
//   each against THRESH and packs VWIDTH bits LSB-first into a vector. Presents each vector
//   on a valid/ready port that drives the shared vecX bus of one bneuron layer.
//   Has one fill register and one output register, so input is sustained at 1 sample/cycle.
// PARAMETERS
//   VWIDTH   32  vector width; must equal the VWIDTH of the downstream bneuron layer
//   CWIDTH   6   counter/popcount width; must satisfy 2**CWIDTH > VWIDTH
//   DWIDTH   8   input sample width, two's complement
//   THRESH   0   signed binarization threshold: bit = (in_data >= THRESH)
//   PAD_BIT  0   value of unfilled bits when a vector is closed early by in_last
// PORTS
//   clk        in   1       single clock; all state updates on the rising edge
//   rst_n      in   1       asynchronous, active-low reset
//   in_valid   in   1       sample valid
//   in_ready   out  1       sample accepted when in_valid & in_ready
//   in_data    in   DWIDTH  signed sample
//   in_last    in   1       last sample of a frame; closes the current vector
//   vec_valid  out  1       output vector valid
//   vec_ready  in   1       consumer accepts when vec_valid & vec_ready
//   vec_data   out  VWIDTH  packed binary vector (feeds vecX)
//   vec_last   out  1       vector was closed by in_last
//   vec_popcnt out  CWIDTH  number of ones in vec_data (only with BIN_PACK_POPCNT_EN)
// BEHAVIOUR
//   Reset (async assert, sync release):
//     - fill register = 0, bit index = 0, state = FILL
//     - vec_valid = 0, vec_data = 0, vec_last = 0, vec_popcnt = 0; in_ready = 1
//   Binarize: signed compare of in_data with THRESH; result is 1 when in_data >= THRESH.
//   Pack: the k-th accepted sample of a vector goes to bit k. The index counts 0..VWIDTH-1.
//   Close: the vector closes on the beat at index VWIDTH-1, or on any beat with in_last=1.
//     - On an in_last close, bits above the index get PAD_BIT.
//     - A full-width close that has in_last=1 also sets vec_last=1.
//   FSM states:
//     - FILL: in_ready = 1.
//     - HOLD: fill register is closed but the output register is occupied; in_ready = 0.
//   Transfer from fill to output register:
//     - On the closing beat, if the output register is free (vec_valid=0, or vec_ready=1
//       that cycle): transfer, index -> 0, stay in FILL.
//     - Otherwise go to HOLD. Transfer on the first cycle the output frees, then go to FILL.
//   Latency: vec_valid rises the cycle after the closing beat (or after the HOLD release).
//   Output hold: vec_data, vec_last and vec_popcnt stay stable while vec_valid & !vec_ready.
//   Output drain: vec_valid drops the cycle after acceptance unless a new vector transfers
//   in that same edge; back-to-back vectors then have no bubble.
//   Simultaneous accept and close: the output handshake and the fill transfer share one edge.
//   The old vector leaves and the new one lands; nothing is lost or duplicated.
//   Reset mid-fill: the partial vector is discarded; the next sample lands at bit 0.
//   Index wrap: the counter never exceeds VWIDTH-1; no overflow state exists.
// CONFIGURATION
//   BIN_PACK_POPCNT_EN defined:
//     - vec_popcnt exists. It is the ones count of the vector, registered with the transfer.
//     - Padding bits are included in the count.
//   BIN_PACK_POPCNT_EN undefined:
//     - the vec_popcnt port and the popcount logic are absent; all other behaviour identical.
// STRUCTURE
//   Shared package/include bnn_pkg:
//     - default VWIDTH/CWIDTH constants shared with bneuron
//     - FSM state encoding (FILL=1'b0, HOLD=1'b1)
//   One sub-module bin_popcount #(VWIDTH,CWIDTH): combinational ones counter, instantiated
//   only under BIN_PACK_POPCNT_EN.
// TESTING (defaults unless stated)
//   1. 32 beats of in_data=8'h01, vec_ready=1 -> vec_data=32'hFFFFFFFF.
//      vec_valid 1 cycle after beat 32; in_ready stays 1.
//   2. Alternate 8'h05, 8'h80 (starting 8'h05) -> vec_data=32'h55555555.
//      vec_popcnt=16, vec_last=0.
//   3. 5 beats of 8'h7F, in_last on beat 5 -> vec_data=32'h0000001F, vec_last=1,
//      vec_popcnt=5. With PAD_BIT=1 -> 32'hFFFFFFFF, vec_popcnt=32.
//   4. vec_ready=0 while 64 beats are offered -> vector 1 held stable in the output register.
//      in_ready=0 after beat 64 (HOLD). vec_ready=1 -> both vectors delivered in order;
//      in_ready returns 1 the cycle after the HOLD transfer.
//   5. Assert rst_n=0 after 10 beats -> outputs 0 immediately.
//      The next 32 beats of 8'h01 -> vec_data=32'hFFFFFFFF (no residue).
//   6. THRESH boundary: in_data=8'h00 -> bit 1; in_data=8'hFF (-1) -> bit 0.
//      Alternating these -> 32'h55555555.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared bneuron constants and the packer FSM state encoding.
package bnn_pkg;

  localparam int unsigned BNN_VWIDTH = 32;
  localparam int unsigned BNN_CWIDTH = 6;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_e;

endpackage

// File: rtl/bin_popcount.sv
// Combinational ones counter over a VWIDTH-bit vector.
module bin_popcount #(
  parameter int unsigned VWIDTH = 32,
  parameter int unsigned CWIDTH = 6
) (
  input  logic [VWIDTH-1:0] vec,
  output logic [CWIDTH-1:0] cnt_c
);

  // Sum every bit of the vector.
  always_comb begin
    cnt_c = '0;
    for (int unsigned i = 0; i < VWIDTH; i++) begin
      cnt_c = cnt_c + CWIDTH'(vec[i]);
    end
  end

endmodule

// File: rtl/bin_vec_packer.sv
// Binarizes a signed sample stream against THRESH and packs VWIDTH bits LSB-first
// into vectors presented on a valid/ready port. One fill register plus one output
// register sustain 1 sample/cycle.
// Optional feature: define BIN_PACK_POPCNT_EN to add the registered vec_popcnt output.
module bin_vec_packer
  import bnn_pkg::*;
#(
  parameter int unsigned VWIDTH  = BNN_VWIDTH,
  parameter int unsigned CWIDTH  = BNN_CWIDTH,
  parameter int unsigned DWIDTH  = 8,
  parameter int          THRESH  = 0,
  parameter bit          PAD_BIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_last,
  output logic              vec_valid,
  input  logic              vec_ready,
  output logic [VWIDTH-1:0] vec_data,
  output logic              vec_last
`ifdef BIN_PACK_POPCNT_EN
  ,
  output logic [CWIDTH-1:0] vec_popcnt
`endif
);

  pack_state_e       state_q, state_d;
  logic [CWIDTH-1:0] idx_q, idx_d;
  logic [VWIDTH-1:0] fill_q, fill_d;
  logic              hold_last_q, hold_last_d;
  logic              vec_valid_d, vec_last_d;
  logic [VWIDTH-1:0] vec_data_d;

  logic              accept_c, close_c, out_free_c, bin_c, load_c, load_last_c;
  logic [VWIDTH-1:0] bit_vec_c, pad_mask_c, closed_vec_c, load_data_c;

  assign in_ready   = (state_q == FILL);
  assign accept_c   = in_valid && (state_q == FILL);
  assign bin_c      = (int'($signed(in_data)) >= THRESH);
  assign close_c    = accept_c && (in_last || (idx_q == CWIDTH'(VWIDTH - 1)));
  assign out_free_c = !vec_valid || vec_ready;
  assign bit_vec_c  = VWIDTH'(bin_c) << idx_q;
  // Bits above the current index; empty at full width since the shift wraps to zero.
  assign pad_mask_c = PAD_BIT ? ~((VWIDTH'(2) << idx_q) - VWIDTH'(1)) : '0;
  assign closed_vec_c = fill_q | bit_vec_c | pad_mask_c;

  // Next-state: fill/close the vector and move it to the output register when free.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    fill_d      = fill_q;
    hold_last_d = hold_last_q;
    load_c      = 1'b0;
    load_data_c = fill_q;
    load_last_c = hold_last_q;
    vec_valid_d = vec_valid && !vec_ready;
    vec_data_d  = vec_data;
    vec_last_d  = vec_last;
    case (state_q)
      FILL: begin
        if (accept_c) begin
          if (close_c) begin
            idx_d = '0;
            if (out_free_c) begin
              load_c      = 1'b1;
              load_data_c = closed_vec_c;
              load_last_c = in_last;
              fill_d      = '0;
            end else begin
              state_d     = HOLD;
              fill_d      = closed_vec_c;
              hold_last_d = in_last;
            end
          end else begin
            idx_d  = idx_q + CWIDTH'(1);
            fill_d = fill_q | bit_vec_c;
          end
        end
      end
      HOLD: begin
        if (out_free_c) begin
          load_c      = 1'b1;
          load_data_c = fill_q;
          load_last_c = hold_last_q;
          fill_d      = '0;
          hold_last_d = 1'b0;
          state_d     = FILL;
        end
      end
      default: state_d = FILL;
    endcase
    if (load_c) begin
      vec_valid_d = 1'b1;
      vec_data_d  = load_data_c;
      vec_last_d  = load_last_c;
    end
  end

  // State, fill and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      idx_q       <= '0;
      fill_q      <= '0;
      hold_last_q <= 1'b0;
      vec_valid   <= 1'b0;
      vec_data    <= '0;
      vec_last    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      fill_q      <= fill_d;
      hold_last_q <= hold_last_d;
      vec_valid   <= vec_valid_d;
      vec_data    <= vec_data_d;
      vec_last    <= vec_last_d;
    end
  end

`ifdef BIN_PACK_POPCNT_EN
  logic [CWIDTH-1:0] pc_c;

  bin_popcount #(
    .VWIDTH(VWIDTH),
    .CWIDTH(CWIDTH)
  ) u_popcount (
    .vec  (load_data_c),
    .cnt_c(pc_c)
  );

  // Ones count captured alongside the vector transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_popcnt <= '0;
    end else if (load_c) begin
      vec_popcnt <= pc_c;
    end
  end
`endif

endmodule
